// File: rtl/tt_um_hoene_manchester_encoder_pkg.sv
// Shared definitions for the Manchester decoder/encoder pair of the LED daisy chain.
// Holds the encoder state encoding, the line idle level and the common pulse-width width.
package tt_um_hoene_manchester_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } enc_state_t;

    localparam logic IDLE_LEVEL   = 1'b0;
    localparam int   DEC_PW_WIDTH = 6;

endpackage

// File: rtl/tt_um_hoene_bit_fifo.sv
// 1-bit wide FIFO with first-word-fall-through read, flush and full/empty flags.
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module tt_um_hoene_bit_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CW'(DEPTH));
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);
    assign dout    = mem_reg[rd_ptr_reg];

    // Storage carries no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/tt_um_hoene_manchester_encoder.sv
// Re-encodes decoded bits as Manchester symbols for the next LED of the chain,
// replaying them from a small FIFO with the half-bit width measured by the decoder.
module tt_um_hoene_manchester_encoder
    import tt_um_hoene_manchester_encoder_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int PW_WIDTH = tt_um_hoene_manchester_encoder_pkg::DEC_PW_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_data,
    input  logic                in_clk,
    input  logic                in_error,
    input  logic [PW_WIDTH-1:0] in_pulsewidth,
    input  logic                in_forward,
    output logic                out,
    output logic                out_busy,
    output logic                out_overflow
);

    enc_state_t          state_reg, state_next;
    logic [PW_WIDTH-1:0] hcnt_reg, hcnt_next;
    logic [PW_WIDTH-1:0] half_reg, half_next;
    logic                bit_reg, bit_next;
    logic                out_reg, out_next;
    logic                overflow_reg;
    logic                fsm_pop;
    logic                push_req;
    logic [PW_WIDTH-1:0] pw_eff;
    logic                fifo_dout;
    logic                fifo_full;
    logic                fifo_empty;

    assign push_req = in_clk & in_forward;
    assign pw_eff   = (in_pulsewidth == '0) ? PW_WIDTH'(1) : in_pulsewidth;

    tt_um_hoene_bit_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push_req & ~in_error),
        .pop  (fsm_pop),
        .flush(in_error),
        .din  (in_data),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        state_next = state_reg;
        hcnt_next  = hcnt_reg;
        half_next  = half_reg;
        bit_next   = bit_reg;
        out_next   = out_reg;
        fsm_pop    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                out_next = IDLE_LEVEL;
                // The half width is captured only here, so a frame keeps one timing.
                if (!fifo_empty) begin
                    fsm_pop    = 1'b1;
                    bit_next   = fifo_dout;
                    half_next  = pw_eff;
                    hcnt_next  = pw_eff - PW_WIDTH'(1);
                    out_next   = ~fifo_dout;
                    state_next = ST_FIRST;
                end
            end
            ST_FIRST: begin
                if (hcnt_reg != '0) begin
                    hcnt_next = hcnt_reg - PW_WIDTH'(1);
                end else begin
                    out_next   = bit_reg;
                    hcnt_next  = half_reg - PW_WIDTH'(1);
                    state_next = ST_SECOND;
                end
            end
            ST_SECOND: begin
                if (hcnt_reg != '0) begin
                    hcnt_next = hcnt_reg - PW_WIDTH'(1);
                end else if (!fifo_empty) begin
                    fsm_pop    = 1'b1;
                    bit_next   = fifo_dout;
                    out_next   = ~fifo_dout;
                    hcnt_next  = half_reg - PW_WIDTH'(1);
                    state_next = ST_FIRST;
                end else begin
                    out_next   = IDLE_LEVEL;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                out_next   = IDLE_LEVEL;
                state_next = ST_IDLE;
            end
        endcase
        if (in_error) begin
            fsm_pop    = 1'b0;
            hcnt_next  = '0;
            out_next   = IDLE_LEVEL;
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            hcnt_reg     <= '0;
            half_reg     <= '0;
            bit_reg      <= 1'b0;
            out_reg      <= IDLE_LEVEL;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            hcnt_reg  <= hcnt_next;
            half_reg  <= half_next;
            bit_reg   <= bit_next;
            out_reg   <= out_next;
            // A same-cycle pop frees a slot, so only a blocked push is an overflow.
            if (in_error) begin
                overflow_reg <= 1'b0;
            end else if (push_req && fifo_full && !fsm_pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign out          = out_reg;
    assign out_busy     = (state_reg != ST_IDLE) | ~fifo_empty;
    assign out_overflow = overflow_reg;

endmodule

// File: tb/tb_tt_um_hoene_manchester_encoder.sv
// Randomized bench for the Manchester encoder: a timeline model schedules every accepted
// bit as a symbol, and a monitor compares the line, busy and overflow outputs each cycle.
module tb_tt_um_hoene_manchester_encoder;

    localparam int DEPTH = 4;

    logic       clk           = 1'b0;
    logic       rst_n         = 1'b0;
    logic       in_data       = 1'b0;
    logic       in_clk        = 1'b0;
    logic       in_error      = 1'b0;
    logic       in_forward    = 1'b0;
    logic [5:0] in_pulsewidth = '0;
    logic       out;
    logic       out_busy;
    logic       out_overflow;

    tt_um_hoene_manchester_encoder #(
        .DEPTH   (DEPTH),
        .PW_WIDTH(6)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_clk       (in_clk),
        .in_error     (in_error),
        .in_pulsewidth(in_pulsewidth),
        .in_forward   (in_forward),
        .out          (out),
        .out_busy     (out_busy),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    // cyc equals k after the k-th rising edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One scheduled symbol: push edge, first edge on the line, half width, end edge.
    typedef struct {
        logic b;
        int   pe;
        int   start;
        int   half;
        int   endc;
    } sym_t;

    sym_t exp_q[$];
    int   starts_q[$];
    int   line_end   = 0;
    int   frame_half = 1;
    bit   pend_valid = 1'b0;
    logic pend_bit   = 1'b0;
    int   pend_pe    = 0;
    int   pend_start = 0;
    logic ovf_pending = 1'b0;
    logic ovf_cur     = 1'b0;
    bit   mon_en      = 1'b0;

    int checks   = 0;
    int failures = 0;
    int symbols  = 0;

    always @(posedge clk) ovf_cur <= ovf_pending;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, expv);
        end
    endfunction

    // Applies inputs for the next edge m and updates the model for what happens at m.
    task automatic drive(input logic c, input logic d, input logic f, input logic e, input int pw);
        int   m;
        int   h;
        bit   pop_at;
        sym_t s;
        @(posedge clk);
        #1;
        in_clk        = c;
        in_data       = d;
        in_forward    = f;
        in_error      = e;
        in_pulsewidth = 6'(pw);
        m = cyc + 1;
        h = (pw == 0) ? 1 : pw;
        // A bit that starts a new frame takes the half width present at its start edge.
        if (pend_valid && pend_start == m) begin
            s.b = pend_bit; s.pe = pend_pe; s.start = m; s.half = h; s.endc = m + 2 * h;
            exp_q.push_back(s);
            line_end   = s.endc;
            frame_half = h;
            pend_valid = 1'b0;
        end
        if (e) begin
            foreach (exp_q[i]) begin
                if (exp_q[i].start >= m) exp_q[i].start = m;
                if (exp_q[i].endc > m)   exp_q[i].endc  = m;
            end
            starts_q.delete();
            pend_valid  = 1'b0;
            line_end    = m;
            ovf_pending = 1'b0;
        end else if (c && f) begin
            while (starts_q.size() > 0 && starts_q[0] < m) void'(starts_q.pop_front());
            pop_at = (starts_q.size() > 0) && (starts_q[0] == m);
            if (starts_q.size() < DEPTH || pop_at) begin
                if (m + 1 <= line_end) begin
                    s.b = d; s.pe = m; s.start = line_end; s.half = frame_half;
                    s.endc = line_end + 2 * frame_half;
                    exp_q.push_back(s);
                    starts_q.push_back(s.start);
                    line_end = s.endc;
                end else begin
                    pend_valid = 1'b1; pend_bit = d; pend_pe = m; pend_start = m + 1;
                    starts_q.push_back(m + 1);
                end
            end else begin
                ovf_pending = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n, input int pw);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, pw);
    endtask

    int   mk;
    logic e_out;
    logic e_busy;

    always @(negedge clk) begin
        if (mon_en) begin
            mk = cyc;
            while (exp_q.size() > 0 && exp_q[0].endc <= mk) begin
                $display("symbol %0d bit=%0d start=%0d half=%0d end=%0d", symbols,
                         exp_q[0].b, exp_q[0].start, exp_q[0].half, exp_q[0].endc);
                symbols++;
                void'(exp_q.pop_front());
            end
            e_out = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].start <= mk) begin
                e_out = (mk < exp_q[0].start + exp_q[0].half) ? ~exp_q[0].b : exp_q[0].b;
            end
            e_busy = 1'b0;
            foreach (exp_q[i]) if (exp_q[i].pe <= mk) e_busy = 1'b1;
            chk("out", 32'(out), 32'(e_out));
            chk("out_busy", 32'(out_busy), 32'(e_busy));
            chk("out_overflow", 32'(out_overflow), 32'(ovf_cur));
        end
    end

    logic bits4 [6];
    int   rpw;
    logic rc, rd, rf, re;

    initial begin
        bits4 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", 32'(out), 32'd0);
        chk("reset_busy", 32'(out_busy), 32'd0);
        chk("reset_overflow", 32'(out_overflow), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // quiet line after reset
        idle(50, 4);
        // bits 1,0 at half width 4
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4);
        idle(20, 4);
        // forwarding disabled
        for (int i = 0; i < 8; i++) drive(1'b1, 1'($urandom), 1'b0, 1'b0, 4);
        idle(5, 4);
        // burst of six into a four-deep FIFO, then clear the sticky flag
        for (int i = 0; i < 6; i++) drive(1'b1, bits4[i], 1'b1, 1'b0, 8);
        idle(100, 8);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8);
        idle(3, 8);
        // abort early in a frame with three bits queued
        for (int i = 0; i < 4; i++) drive(1'b1, 1'($urandom), 1'b1, 1'b0, 4);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 4);
        idle(30, 4);
        // zero width, then a width change mid-frame
        for (int i = 0; i < 3; i++) drive(1'b1, 1'($urandom), 1'b1, 1'b0, 0);
        idle(10, 0);
        for (int i = 0; i < 4; i++) drive(1'b1, 1'($urandom), 1'b1, 1'b0, 3);
        idle(40, 6);
        for (int i = 0; i < 2; i++) drive(1'b1, 1'($urandom), 1'b1, 1'b0, 6);
        idle(30, 6);

        rpw = 2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 63) == 0) rpw = $urandom_range(0, 5);
            rc = ($urandom_range(0, 3) == 0);
            rd = 1'($urandom);
            rf = ($urandom_range(0, 9) != 0);
            re = ($urandom_range(0, 199) == 0);
            drive(rc, rd, rf, re, rpw);
        end

        for (int i = 0; i < 400 && (exp_q.size() > 0 || pend_valid); i++) idle(1, rpw);
        idle(2, rpw);
        chk("drain_queue", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", 32'(out_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
